// File: rtl/axis_uart_pkg.sv
// Shared constants, state encoding and command-frame byte selection
// for the AXI-Lite UART bridge host-side initiator.
package axis_uart_pkg;

   localparam logic [7:0] DEFAULT_BYTE_START = 8'hF0;
   localparam logic [7:0] DEFAULT_BYTE_WR    = 8'hA1;
   localparam logic [7:0] DEFAULT_BYTE_RD    = 8'hA2;

   localparam int CMD_FRAME_BYTES = 10;
   localparam int RSP_FRAME_BYTES = 11;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      TX   = 3'd1,
      HUNT = 3'd2,
      RX   = 3'd3,
      RESP = 3'd4
   } state_t;

   // Byte idx of the command frame: START, addr MSB first, data MSB first, opcode.
   function automatic logic [7:0] cmd_frame_byte(input logic [3:0]  idx,
                                                 input logic [31:0] addr,
                                                 input logic [31:0] data,
                                                 input logic [7:0]  start,
                                                 input logic [7:0]  op);
      logic [7:0] b;
      case (idx)
         4'd0:    b = start;
         4'd1:    b = addr[31:24];
         4'd2:    b = addr[23:16];
         4'd3:    b = addr[15:8];
         4'd4:    b = addr[7:0];
         4'd5:    b = data[31:24];
         4'd6:    b = data[23:16];
         4'd7:    b = data[15:8];
         4'd8:    b = data[7:0];
         4'd9:    b = op;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/axis_uart_rsp_parser.sv
// Response-frame field capture: addr x4, data x4, error byte, then opcode.
// The opcode byte is not stored; done flags it so the top can compare it live.
module axis_uart_rsp_parser
   import axis_uart_pkg::*;
(
   input  logic        clk,
   input  logic        areset,
   input  logic        frame_start,
   input  logic        capture,
   input  logic [7:0]  byte_data,
   output logic        done,
   output logic [31:0] addr,
   output logic [31:0] data,
   output logic [1:0]  error
);

   localparam logic [3:0] LAST_IDX = 4'(RSP_FRAME_BYTES - 2);

   logic [3:0] idx_r;

   assign done = capture && (idx_r == LAST_IDX);

   // Field index and shift-in of big-endian addr/data fields.
   always_ff @(posedge clk) begin
      if (areset) begin
         idx_r <= 4'd0;
         addr  <= 32'h0;
         data  <= 32'h0;
         error <= 2'b00;
      end else if (frame_start) begin
         idx_r <= 4'd0;
      end else if (capture) begin
         case (idx_r)
            4'd0, 4'd1, 4'd2, 4'd3: addr  <= {addr[23:0], byte_data};
            4'd4, 4'd5, 4'd6, 4'd7: data  <= {data[23:0], byte_data};
            4'd8:                   error <= byte_data[1:0];
            default:                ;
         endcase
         idx_r <= (idx_r == LAST_IDX) ? 4'd0 : idx_r + 4'd1;
      end
   end

endmodule

// File: rtl/axis_uart_cmd_initiator.sv
// Host-side initiator: serialises one wr/rd request into a 10-byte command
// frame, then waits (bounded) for the 11-byte response and reports it on rsp.
module axis_uart_cmd_initiator
   import axis_uart_pkg::*;
#(
   parameter logic [7:0] UART_BYTE_START = DEFAULT_BYTE_START,
   parameter logic [7:0] UART_BYTE_WR    = DEFAULT_BYTE_WR,
   parameter logic [7:0] UART_BYTE_RD    = DEFAULT_BYTE_RD,
   parameter int         TIMEOUT_CYCLES  = 1_000_000
)(
   input  logic        aclk,
   input  logic        areset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_error,
   output logic        rsp_mismatch,
   output logic        rsp_timeout,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [7:0]  m_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic [7:0]  s_axis_tdata
);

   localparam logic [3:0]  TX_LAST  = 4'(CMD_FRAME_BYTES - 1);
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      state_r;
   logic        wr_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  tx_idx_r;
   logic [31:0] tmo_cnt_r;

   logic        byte_fire_s;
   logic        frame_start_s;
   logic        capture_s;
   logic        done_s;
   logic [7:0]  op_s;
   logic [31:0] p_addr_s;
   logic [31:0] p_data_s;
   logic [1:0]  p_error_s;

   assign op_s          = wr_r ? UART_BYTE_WR : UART_BYTE_RD;
   assign byte_fire_s   = s_axis_tvalid && s_axis_tready;
   assign frame_start_s = byte_fire_s && (state_r == HUNT) && (s_axis_tdata == UART_BYTE_START);
   assign capture_s     = byte_fire_s && (state_r == RX);

   axis_uart_rsp_parser u_parser (
      .clk         (aclk),
      .areset      (areset),
      .frame_start (frame_start_s),
      .capture     (capture_s),
      .byte_data   (s_axis_tdata),
      .done        (done_s),
      .addr        (p_addr_s),
      .data        (p_data_s),
      .error       (p_error_s)
   );

   // Transaction FSM with registered handshakes and response fields.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r       <= IDLE;
         cmd_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_data      <= 32'h0;
         rsp_error     <= 2'b00;
         rsp_mismatch  <= 1'b0;
         rsp_timeout   <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= 8'h00;
         s_axis_tready <= 1'b0;
         wr_r          <= 1'b0;
         addr_r        <= 32'h0;
         wdata_r       <= 32'h0;
         tx_idx_r      <= 4'd0;
         tmo_cnt_r     <= 32'h0;
      end else begin
         case (state_r)
            IDLE: begin
               if (cmd_valid) begin
                  wr_r          <= cmd_wr;
                  addr_r        <= cmd_addr;
                  wdata_r       <= cmd_wr ? cmd_wdata : 32'h0;
                  cmd_ready     <= 1'b0;
                  tx_idx_r      <= 4'd0;
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= UART_BYTE_START;
                  state_r       <= TX;
               end
            end
            TX: begin
               if (m_axis_tvalid && m_axis_tready) begin
                  if (tx_idx_r == TX_LAST) begin
                     m_axis_tvalid <= 1'b0;
                     tmo_cnt_r     <= 32'h0;
                     s_axis_tready <= 1'b1;
                     state_r       <= HUNT;
                  end else begin
                     tx_idx_r     <= tx_idx_r + 4'd1;
                     m_axis_tdata <= cmd_frame_byte(tx_idx_r + 4'd1, addr_r, wdata_r,
                                                    UART_BYTE_START, op_s);
                  end
               end
            end
            HUNT, RX: begin
               tmo_cnt_r <= tmo_cnt_r + 32'd1;
               if (frame_start_s) begin
                  state_r <= RX;
               end
               // A complete frame takes priority over an expiring timeout.
               if (done_s) begin
                  s_axis_tready <= 1'b0;
                  rsp_valid     <= 1'b1;
                  rsp_data      <= p_data_s;
                  rsp_error     <= p_error_s;
                  rsp_mismatch  <= (p_addr_s != addr_r) || (s_axis_tdata != op_s);
                  rsp_timeout   <= 1'b0;
                  state_r       <= RESP;
               end else if (tmo_cnt_r == TMO_LAST) begin
                  s_axis_tready <= 1'b0;
                  rsp_valid     <= 1'b1;
                  rsp_data      <= 32'h0;
                  rsp_error     <= 2'b00;
                  rsp_mismatch  <= 1'b0;
                  rsp_timeout   <= 1'b1;
                  state_r       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_uart_cmd_initiator.sv
// Directed bench for axis_uart_cmd_initiator: command framing, response parsing,
// mismatch, timeout, response hold and mid-frame reset.
module tb_axis_uart_cmd_initiator;

   logic        clk = 1'b0;
   logic        areset;
   logic        cmd_valid, cmd_ready, cmd_wr;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_error;
   logic        rsp_mismatch, rsp_timeout;
   logic        m_tvalid, m_tready;
   logic [7:0]  m_tdata;
   logic        s_tvalid, s_tready;
   logic [7:0]  s_tdata;

   int checks   = 0;
   int failures = 0;

   logic [7:0] rbuf [0:15];
   int         rlen;

   always #5 clk = ~clk;

   axis_uart_cmd_initiator #(.TIMEOUT_CYCLES(64)) dut (
      .aclk          (clk),
      .areset        (areset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_wr        (cmd_wr),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_error     (rsp_error),
      .rsp_mismatch  (rsp_mismatch),
      .rsp_timeout   (rsp_timeout),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
      cmd_wr    = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_valid = 1'b1;
      chk("cmd_ready_idle", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("tx_first_valid", m_tvalid, 1);
      chk("tx_first_byte", m_tdata, 8'hF0);
   endtask

   task automatic collect_tx(input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit toggle);
      logic [7:0] exp [0:9];
      logic [31:0] d;
      logic [7:0] held;
      bit stalled;
      int n;
      int cyc;
      d = wr ? wdata : 32'h0;
      exp[0] = 8'hF0;
      for (int i = 0; i < 4; i++) exp[1+i] = addr[31-8*i -: 8];
      for (int i = 0; i < 4; i++) exp[5+i] = d[31-8*i -: 8];
      exp[9] = wr ? 8'hA1 : 8'hA2;
      n = 0; cyc = 0; stalled = 0; held = 8'h00;
      while (n < 10 && cyc < 100) begin
         m_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
         if (stalled) begin
            chk("tx_hold_valid", m_tvalid, 1);
            chk("tx_hold_data", m_tdata, held);
         end
         stalled = 0;
         if (m_tvalid && m_tready) begin
            chk($sformatf("tx_byte%0d", n), m_tdata, exp[n]);
            n++;
         end else if (m_tvalid) begin
            stalled = 1;
            held    = m_tdata;
         end
         tick();
         cyc++;
      end
      m_tready = 1'b0;
      chk("tx_count", n, 10);
      chk("tx_done_valid", m_tvalid, 0);
      chk("hunt_tready", s_tready, 1);
   endtask

   task automatic push_frame(input logic [31:0] addr, input logic [31:0] data,
                             input logic [7:0] err, input logic [7:0] op);
      rbuf[rlen] = 8'hF0; rlen++;
      for (int i = 0; i < 4; i++) begin rbuf[rlen] = addr[31-8*i -: 8]; rlen++; end
      for (int i = 0; i < 4; i++) begin rbuf[rlen] = data[31-8*i -: 8]; rlen++; end
      rbuf[rlen] = err; rlen++;
      rbuf[rlen] = op;  rlen++;
   endtask

   task automatic send_rsp();
      int w;
      for (int i = 0; i < rlen; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = rbuf[i];
         w = 0;
         while (!s_tready && w < 50) begin
            tick();
            w++;
         end
         if (w >= 50) chk("rx_tready_wait", s_tready, 1);
         tick();
      end
      s_tvalid = 1'b0;
      rlen = 0;
   endtask

   task automatic expect_rsp(input logic [31:0] data, input logic [1:0] err,
                             input logic mism, input logic tmo);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, data);
      chk("rsp_error", rsp_error, err);
      chk("rsp_mismatch", rsp_mismatch, mism);
      chk("rsp_timeout", rsp_timeout, tmo);
      chk("resp_tready", s_tready, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rsp_valid_clr", rsp_valid, 0);
      chk("cmd_ready_back", cmd_ready, 1);
   endtask

   initial begin
      int k;
      areset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
      rsp_ready = 1'b0; m_tready = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; rlen = 0;
      repeat (3) tick();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_flags", {rsp_error, rsp_mismatch, rsp_timeout}, 0);
      areset = 1'b0;
      tick();

      // Write with tready held high.
      send_cmd(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
      collect_tx(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
      push_frame(32'h0000_1000, 32'hDEAD_BEEF, 8'h00, 8'hA1);
      send_rsp();
      expect_rsp(32'hDEAD_BEEF, 2'd0, 1'b0, 1'b0);

      // Read with toggling tready; write data field must be zero.
      tick();
      send_cmd(1'b0, 32'h4000_0004, 32'hFFFF_FFFF);
      collect_tx(1'b0, 32'h4000_0004, 32'hFFFF_FFFF, 1'b1);
      push_frame(32'h4000_0004, 32'h1234_5678, 8'h02, 8'hA2);
      send_rsp();
      expect_rsp(32'h1234_5678, 2'd2, 1'b0, 1'b0);

      // Garbage before START; START bytes inside the data field are data.
      send_cmd(1'b0, 32'h0000_2000, 32'h0);
      collect_tx(1'b0, 32'h0000_2000, 32'h0, 1'b0);
      rbuf[0] = 8'h11; rbuf[1] = 8'h22; rlen = 2;
      push_frame(32'h0000_2000, 32'hF00D_F0F0, 8'h01, 8'hA2);
      send_rsp();
      expect_rsp(32'hF00D_F0F0, 2'd1, 1'b0, 1'b0);

      // Echoed address differs; response held 20 cycles before consumption.
      send_cmd(1'b1, 32'h0000_1000, 32'h1111_1111);
      collect_tx(1'b1, 32'h0000_1000, 32'h1111_1111, 1'b0);
      push_frame(32'h0000_1004, 32'h1111_1111, 8'h00, 8'hA1);
      send_rsp();
      repeat (20) tick();
      chk("hold_cmd_ready", cmd_ready, 0);
      expect_rsp(32'h1111_1111, 2'd0, 1'b1, 1'b0);

      // Opcode echo differs from the command.
      send_cmd(1'b1, 32'h0000_0008, 32'h0000_0000);
      collect_tx(1'b1, 32'h0000_0008, 32'h0000_0000, 1'b0);
      push_frame(32'h0000_0008, 32'hABCD_0123, 8'h03, 8'hA2);
      send_rsp();
      expect_rsp(32'hABCD_0123, 2'd3, 1'b1, 1'b0);

      // No reply: timeout lands exactly 64 cycles after the last command byte.
      send_cmd(1'b0, 32'h0000_3000, 32'h0);
      collect_tx(1'b0, 32'h0000_3000, 32'h0, 1'b0);
      k = 0;
      while (!rsp_valid && k < 100) begin
         tick();
         k++;
      end
      chk("timeout_latency", k, 64);
      s_tvalid = 1'b1;
      s_tdata  = 8'hF0;
      repeat (3) tick();
      chk("late_byte_stall", s_tready, 0);
      expect_rsp(32'h0, 2'd0, 1'b0, 1'b1);
      s_tvalid = 1'b0;

      // Reset in the middle of the command frame.
      send_cmd(1'b1, 32'h0000_5000, 32'h0000_0001);
      m_tready = 1'b1;
      repeat (3) tick();
      m_tready = 1'b0;
      areset = 1'b1;
      tick();
      chk("mid_rst_tvalid", m_tvalid, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      areset = 1'b0;
      tick();
      chk("post_rst_tvalid", m_tvalid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
